// File: rtl/des_sbox_arbiter.sv
// Round-robin arbiter sharing one DES S-box bank between two round engines.
// Two-edge latency: accept -> stage-1 register -> per-requester response slot.
module des_sbox_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             req_valid_a,
  input  logic [47:0]      req_data_a,
  input  logic [TAG_W-1:0] req_tag_a,
  output logic             req_ready_a,
  input  logic             req_valid_b,
  input  logic [47:0]      req_data_b,
  input  logic [TAG_W-1:0] req_tag_b,
  output logic             req_ready_b,
  output logic [47:0]      sub_in,
  input  logic [31:0]      sub_out,
  output logic             rsp_valid_a,
  output logic [31:0]      rsp_data_a,
  output logic [TAG_W-1:0] rsp_tag_a,
  input  logic             rsp_ready_a,
  output logic             rsp_valid_b,
  output logic [31:0]      rsp_data_b,
  output logic [TAG_W-1:0] rsp_tag_b,
  input  logic             rsp_ready_b,
  output logic             busy
);

  localparam logic OwnerA = 1'b0;
  localparam logic OwnerB = 1'b1;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_owner_q, s1_owner_d;
  logic [47:0]      s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             last_grant_q, last_grant_d;
  logic             slot_a_valid_q, slot_a_valid_d;
  logic [31:0]      slot_a_data_q, slot_a_data_d;
  logic [TAG_W-1:0] slot_a_tag_q, slot_a_tag_d;
  logic             slot_b_valid_q, slot_b_valid_d;
  logic [31:0]      slot_b_data_q, slot_b_data_d;
  logic [TAG_W-1:0] slot_b_tag_q, slot_b_tag_d;
  logic             elig_a, elig_b, grant_a, grant_b;

  // A requester may not issue while its own word is in stage 1 or its slot is stuck.
  always_comb begin
    elig_a  = req_valid_a && !(s1_valid_q && s1_owner_q == OwnerA)
              && !(slot_a_valid_q && !rsp_ready_a);
    elig_b  = req_valid_b && !(s1_valid_q && s1_owner_q == OwnerB)
              && !(slot_b_valid_q && !rsp_ready_b);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (n_rst && !clear) begin
      if (elig_a && elig_b) begin
        grant_a = (last_grant_q == OwnerB);
        grant_b = (last_grant_q == OwnerA);
      end else begin
        grant_a = elig_a;
        grant_b = elig_b;
      end
    end
  end

  always_comb begin
    s1_valid_d     = grant_a | grant_b;
    s1_owner_d     = s1_owner_q;
    s1_data_d      = s1_data_q;
    s1_tag_d       = s1_tag_q;
    last_grant_d   = last_grant_q;
    slot_a_valid_d = slot_a_valid_q;
    slot_a_data_d  = slot_a_data_q;
    slot_a_tag_d   = slot_a_tag_q;
    slot_b_valid_d = slot_b_valid_q;
    slot_b_data_d  = slot_b_data_q;
    slot_b_tag_d   = slot_b_tag_q;

    if (grant_a) begin
      s1_owner_d   = OwnerA;
      s1_data_d    = req_data_a;
      s1_tag_d     = req_tag_a;
      last_grant_d = OwnerA;
    end else if (grant_b) begin
      s1_owner_d   = OwnerB;
      s1_data_d    = req_data_b;
      s1_tag_d     = req_tag_b;
      last_grant_d = OwnerB;
    end

    if (slot_a_valid_q && rsp_ready_a) slot_a_valid_d = 1'b0;
    if (slot_b_valid_q && rsp_ready_b) slot_b_valid_d = 1'b0;

    // A reload in the same edge as a pop takes priority.
    if (s1_valid_q && s1_owner_q == OwnerA) begin
      slot_a_valid_d = 1'b1;
      slot_a_data_d  = sub_out;
      slot_a_tag_d   = s1_tag_q;
    end
    if (s1_valid_q && s1_owner_q == OwnerB) begin
      slot_b_valid_d = 1'b1;
      slot_b_data_d  = sub_out;
      slot_b_tag_d   = s1_tag_q;
    end

    if (clear) begin
      s1_valid_d     = 1'b0;
      slot_a_valid_d = 1'b0;
      slot_b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q     <= 1'b0;
      s1_owner_q     <= OwnerA;
      s1_data_q      <= '0;
      s1_tag_q       <= '0;
      last_grant_q   <= OwnerB;
      slot_a_valid_q <= 1'b0;
      slot_a_data_q  <= '0;
      slot_a_tag_q   <= '0;
      slot_b_valid_q <= 1'b0;
      slot_b_data_q  <= '0;
      slot_b_tag_q   <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_owner_q     <= s1_owner_d;
      s1_data_q      <= s1_data_d;
      s1_tag_q       <= s1_tag_d;
      last_grant_q   <= last_grant_d;
      slot_a_valid_q <= slot_a_valid_d;
      slot_a_data_q  <= slot_a_data_d;
      slot_a_tag_q   <= slot_a_tag_d;
      slot_b_valid_q <= slot_b_valid_d;
      slot_b_data_q  <= slot_b_data_d;
      slot_b_tag_q   <= slot_b_tag_d;
    end
  end

  assign req_ready_a = grant_a;
  assign req_ready_b = grant_b;
  assign sub_in      = s1_data_q;
  assign rsp_valid_a = slot_a_valid_q;
  assign rsp_data_a  = slot_a_data_q;
  assign rsp_tag_a   = slot_a_tag_q;
  assign rsp_valid_b = slot_b_valid_q;
  assign rsp_data_b  = slot_b_data_q;
  assign rsp_tag_b   = slot_b_tag_q;
  assign busy        = s1_valid_q | slot_a_valid_q | slot_b_valid_q;

endmodule

// File: tb/tb_des_sbox_arbiter.sv
// Bench for des_sbox_arbiter: real DES S-box bank, queue-based reference model
// of grants and responses, directed scenarios plus randomized traffic.
module tb_des_sbox_arbiter;
  localparam int unsigned TAG_W = 4;

  logic             clk, n_rst, clear;
  logic             req_valid_a, req_ready_a, req_valid_b, req_ready_b;
  logic [47:0]      req_data_a, req_data_b, sub_in;
  logic [TAG_W-1:0] req_tag_a, req_tag_b, rsp_tag_a, rsp_tag_b;
  logic [31:0]      sub_out, rsp_data_a, rsp_data_b;
  logic             rsp_valid_a, rsp_ready_a, rsp_valid_b, rsp_ready_b, busy;

  des_sbox_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .req_valid_a(req_valid_a), .req_data_a(req_data_a), .req_tag_a(req_tag_a),
    .req_ready_a(req_ready_a),
    .req_valid_b(req_valid_b), .req_data_b(req_data_b), .req_tag_b(req_tag_b),
    .req_ready_b(req_ready_b),
    .sub_in(sub_in), .sub_out(sub_out),
    .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a), .rsp_tag_a(rsp_tag_a),
    .rsp_ready_a(rsp_ready_a),
    .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b), .rsp_tag_b(rsp_tag_b),
    .rsp_ready_b(rsp_ready_b),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // DES S-boxes: sb[box][row], column c at nibble [63-4c -: 4].
  logic [63:0] sb [8][4];
  initial begin
    sb[0][0] = 64'hE4D12FB83A6C5907; sb[0][1] = 64'h0F74E2D1A6CB9538;
    sb[0][2] = 64'h41E8D62BFC973A50; sb[0][3] = 64'hFC8249175B3EA06D;
    sb[1][0] = 64'hF18E6B34972DC05A; sb[1][1] = 64'h3D47F28EC01A69B5;
    sb[1][2] = 64'h0E7BA4D158C6932F; sb[1][3] = 64'hD8A13F42B67C05E9;
    sb[2][0] = 64'hA09E63F51DC7B428; sb[2][1] = 64'hD70934A6285ECBF1;
    sb[2][2] = 64'hD6498F30B12C5AE7; sb[2][3] = 64'h1AD069874FE3B52C;
    sb[3][0] = 64'h7DE3069A1285BC4F; sb[3][1] = 64'hD8B56F03472C1AE9;
    sb[3][2] = 64'hA690CB7DF13E5284; sb[3][3] = 64'h3F06A1D8945BC72E;
    sb[4][0] = 64'h2C417AB6853FD0E9; sb[4][1] = 64'hEB2C47D150FA3986;
    sb[4][2] = 64'h421BAD78F9C5630E; sb[4][3] = 64'hB8C71E2D6F09A453;
    sb[5][0] = 64'hC1AF92680D34E75B; sb[5][1] = 64'hAF427C9561DE0B38;
    sb[5][2] = 64'h9EF528C3704A1DB6; sb[5][3] = 64'h432C95FABE17608D;
    sb[6][0] = 64'h4B2EF08D3C975A61; sb[6][1] = 64'hD0B7491AE35C2F86;
    sb[6][2] = 64'h14BDC37EAF680592; sb[6][3] = 64'h6BD814A7950FE23C;
    sb[7][0] = 64'hD2846FB1A93E50C7; sb[7][1] = 64'h1FD8A374C56B0E92;
    sb[7][2] = 64'h7B419CE206ADF358; sb[7][3] = 64'h21E74A8DFC90356B;
  end

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] r;
    logic [5:0]  b;
    logic [63:0] row;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[47-6*i -: 6];
      row = sb[i][{b[5], b[0]}];
      r[31-4*i -: 4] = row[63-4*int'(b[4:1]) -: 4];
    end
    return r;
  endfunction

  always_comb sub_out = sbox_f(sub_in);

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted word becomes an entry due in its slot at cyc+2.
  typedef struct {
    logic [31:0]      dout;
    logic [TAG_W-1:0] tag;
    int               due;
  } ent_t;
  ent_t        qa[$];
  ent_t        qb[$];
  logic        m_last;  // 0 = A, 1 = B
  logic [47:0] m_sub;
  logic        hs_a = 1'b0, hs_b = 1'b0;

  always @(negedge clk) begin : mon
    logic sva, svb, s1a, s1b, ea, eb, ga, gb;
    if (!n_rst) begin
      chk("rst_ready", 64'({req_ready_a, req_ready_b}), 64'(0));
      chk("rst_rsp_valid", 64'({rsp_valid_a, rsp_valid_b, busy}), 64'(0));
      chk("rst_rsp_data", {rsp_data_a, rsp_data_b}, 64'(0));
      chk("rst_rsp_tag_sub", 64'({rsp_tag_a, rsp_tag_b, sub_in}), 64'(0));
      qa.delete();
      qb.delete();
      m_last = 1'b1;
      m_sub  = '0;
      hs_a   = 1'b0;
      hs_b   = 1'b0;
    end else begin
      sva = qa.size() > 0 && qa[0].due <= cyc;
      svb = qb.size() > 0 && qb[0].due <= cyc;
      s1a = qa.size() > 0 && qa[$].due == cyc + 1;
      s1b = qb.size() > 0 && qb[$].due == cyc + 1;
      ea  = req_valid_a && !s1a && !(sva && !rsp_ready_a) && !clear;
      eb  = req_valid_b && !s1b && !(svb && !rsp_ready_b) && !clear;
      ga  = ea && (!eb || m_last);
      gb  = eb && (!ea || !m_last);
      chk("req_ready_a", 64'(req_ready_a), 64'(ga));
      chk("req_ready_b", 64'(req_ready_b), 64'(gb));
      chk("rsp_valid_a", 64'(rsp_valid_a), 64'(sva));
      chk("rsp_valid_b", 64'(rsp_valid_b), 64'(svb));
      if (sva) chk("rsp_a", 64'({rsp_data_a, rsp_tag_a}), 64'({qa[0].dout, qa[0].tag}));
      if (svb) chk("rsp_b", 64'({rsp_data_b, rsp_tag_b}), 64'({qb[0].dout, qb[0].tag}));
      chk("busy", 64'(busy), 64'(qa.size() + qb.size() != 0));
      chk("sub_in", 64'(sub_in), 64'(m_sub));
      hs_a = req_valid_a && req_ready_a;
      hs_b = req_valid_b && req_ready_b;
      if (sva && rsp_ready_a) void'(qa.pop_front());
      if (svb && rsp_ready_b) void'(qb.pop_front());
      if (clear) begin
        qa.delete();
        qb.delete();
      end else if (ga) begin
        qa.push_back('{dout: sbox_f(req_data_a), tag: req_tag_a, due: cyc + 2});
        m_last = 1'b0;
        m_sub  = req_data_a;
      end else if (gb) begin
        qb.push_back('{dout: sbox_f(req_data_b), tag: req_tag_b, due: cyc + 2});
        m_last = 1'b1;
        m_sub  = req_data_b;
      end
    end
  end

  // Requesters keep valid/data/tag stable until their word is taken.
  task automatic drive(input int unsigned pa, input int unsigned pb, input int unsigned pra,
                       input int unsigned prb, input int unsigned pclr);
    @(posedge clk); #1;
    if (!(req_valid_a && !hs_a)) begin
      req_valid_a = ($urandom_range(99) < pa);
      req_data_a  = rnd48();
      req_tag_a   = TAG_W'($urandom());
    end
    if (!(req_valid_b && !hs_b)) begin
      req_valid_b = ($urandom_range(99) < pb);
      req_data_b  = rnd48();
      req_tag_b   = TAG_W'($urandom());
    end
    rsp_ready_a = ($urandom_range(99) < pra);
    rsp_ready_b = ($urandom_range(99) < prb);
    clear       = ($urandom_range(99) < pclr);
  endtask

  task automatic quiesce();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (!(req_valid_a && !hs_a)) req_valid_a = 1'b0;
      if (!(req_valid_b && !hs_b)) req_valid_b = 1'b0;
      rsp_ready_a = 1'b1;
      rsp_ready_b = 1'b1;
      clear       = 1'b0;
    end
  endtask

  int accepts;

  initial begin
    n_rst = 1'b0; clear = 1'b0;
    req_valid_a = 1'b0; req_data_a = '0; req_tag_a = '0;
    req_valid_b = 1'b0; req_data_b = '0; req_tag_b = '0;
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Single request of the all-zero word through the real S-boxes.
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_data_a = '0; req_tag_a = 4'd3; rsp_ready_a = 1'b0;
    #1 chk("single_ready", 64'(req_ready_a), 64'(1));
    @(posedge clk); #1 req_valid_a = 1'b0;
    @(posedge clk); #1;
    chk("single_valid", 64'(rsp_valid_a), 64'(1));
    chk("single_data", 64'(rsp_data_a), 64'h0000_0000_EFA7_2C4D);
    chk("single_tag", 64'(rsp_tag_a), 64'(3));
    @(posedge clk); #1;
    chk("single_hold", 64'({rsp_valid_a, rsp_data_a, rsp_tag_a}), 64'({1'b1, 32'hEFA72C4D, 4'd3}));
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    chk("single_busy_drop", 64'({busy, rsp_valid_a}), 64'(0));

    repeat (20) drive(100, 100, 100, 100, 0);   // contention
    repeat (10) drive(100, 100, 0, 100, 0);     // A backpressured
    drive(100, 100, 100, 100, 0);
    repeat (6) drive(100, 100, 0, 100, 0);

    // Single requester: one accept every other cycle.
    quiesce();
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0 || hs_a) begin
        req_data_a = rnd48();
        req_tag_a  = TAG_W'(i);
      end
      req_valid_a = 1'b1;
      #1 chk("solo_ready", 64'(req_ready_a), 64'(i % 2 == 0));
      if (req_ready_a) accepts++;
    end
    chk("solo_accepts", 64'(accepts), 64'(5));

    // clear with A in stage 1 and B's slot full.
    quiesce();
    @(posedge clk); #1;
    rsp_ready_b = 1'b0; req_valid_b = 1'b1; req_data_b = rnd48(); req_tag_b = 4'd5;
    @(posedge clk); #1;
    req_valid_b = 1'b0; req_valid_a = 1'b1; req_data_a = rnd48(); req_tag_a = 4'd6;
    @(posedge clk); #1;
    req_valid_a = 1'b0; clear = 1'b1;
    chk("pre_clear", 64'({busy, rsp_valid_b}), 64'(3));
    @(posedge clk); #1;
    clear = 1'b0;
    chk("post_clear", 64'({rsp_valid_a, rsp_valid_b, busy}), 64'(0));
    rsp_ready_b = 1'b1;
    req_valid_a = 1'b1; req_data_a = rnd48();
    req_valid_b = 1'b1; req_data_b = rnd48();
    #1 chk("clear_tie", 64'({req_ready_a, req_ready_b}), 64'(1));
    quiesce();

    repeat (400) drive(60, 60, 70, 70, 3);

    // Asynchronous reset between edges.
    repeat (5) drive(100, 100, 100, 100, 0);
    @(posedge clk); #2 n_rst = 1'b0;
    #1;
    chk("arst_ready", 64'({req_ready_a, req_ready_b}), 64'(0));
    chk("arst_rsp", 64'({rsp_valid_a, rsp_valid_b, busy, rsp_tag_a, rsp_tag_b}), 64'(0));
    chk("arst_data", {rsp_data_a, rsp_data_b}, 64'(0));
    chk("arst_sub", 64'(sub_in), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    req_valid_a = 1'b1; req_valid_b = 1'b1;
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
    #1 chk("arst_first_tie", 64'({req_ready_a, req_ready_b}), 64'(2));
    repeat (10) drive(80, 80, 80, 80, 0);
    quiesce();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/des_sbox_arbiter.md
Name: des_sbox_arbiter

Overview:
- Shares one DES substitution stage (S1..S8 bank: 48-bit in, 32-bit combinational out) between two round engines, A and B (e.g. the encrypt and decrypt lanes of 3DES).
- Accepts 48-bit key-mixed expansion words from each requester and arbitrates round-robin.
- Registers the winner onto the shared bank, then captures the 32-bit result into a per-requester response slot that holds until consumed.

Parameters:
- TAG_W, 4, width of the requester-supplied tag returned with each response.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all in-flight and pending work.
- req_valid_a  input  1  requester A has a word.
- req_data_a  input  48  requester A expansion XOR subkey.
- req_tag_a  input  TAG_W  requester A tag.
- req_ready_a  output  1  A's word is accepted this cycle.
- req_valid_b, req_data_b, req_tag_b, req_ready_b  same as A, for requester B.
- sub_in  output  48  to the shared S-box bank; bits 47:42 feed S1 … bits 5:0 feed S8.
- sub_out  input  32  from the bank; bits 31:28 from S1 … bits 3:0 from S8.
- rsp_valid_a  output  1  result pending for A.
- rsp_data_a  output  32  result for A.
- rsp_tag_a  output  TAG_W  tag for A.
- rsp_ready_a  input  1  A consumes its result.
- rsp_valid_b, rsp_data_b, rsp_tag_b, rsp_ready_b  same as A, for requester B.
- busy  output  1  any stage or response slot occupied.

Behaviour:
- Reset (n_rst low, asynchronous):
  - s1_valid=0, s1_owner=A, s1_data=0, s1_tag=0.
  - Both response slots empty with data and tag 0.
  - last_grant=B, so A wins the first tie.
  - Outputs: req_ready_a/b=0, rsp_valid_a/b=0, rsp_data/tag=0, sub_in=0, busy=0.
  - Reset mid-operation discards everything; no response is produced for words accepted before reset.
- Pipeline:
  - Stage 1 register holds {valid, owner, data, tag}; sub_in = s1_data directly from the register.
  - Response slot per requester holds {valid, data, tag}.
  - Accept at edge N → s1 valid in cycle N+1 → slot valid, rsp_valid high from cycle N+2.
  - Fixed latency of 2 edges.
- Eligibility (x in {A,B}):
  - elig_x = req_valid_x && !(s1_valid && s1_owner==x) && !(rsp_valid_x && !rsp_ready_x).
  - Consequence: one requester alone can issue at most every other cycle; two alternating requesters sustain one word per cycle.
- Arbitration (combinational, each cycle):
  - Only one eligible → grant it.
  - Both eligible → grant the requester that is not last_grant.
  - Neither eligible → no grant.
  - req_ready_x = grant_x, so it is never high for both.
  - Ready may depend on valid. Requesters must not drop valid or change data/tag while valid && !ready.
- Handshake effects:
  - On accept: load s1 (valid=1, owner, data, tag) and set last_grant=x.
  - No accept: s1_valid=0 next cycle; s1_data/tag hold their value.
- Response capture:
  - When s1_valid, load slot[s1_owner] with {1, sub_out, s1_tag} at the edge.
  - Slot clears on rsp_valid && rsp_ready, unless it is reloaded in the same edge, in which case the load wins.
  - rsp_data/tag stay stable while rsp_valid && !rsp_ready.
- clear (sync): at the edge, s1_valid=0 and both slots go invalid.
  - req_ready is forced 0 during the clear cycle, so no accept happens concurrently.
  - last_grant is unchanged.
- Simultaneous pop and accept of the same requester is permitted, provided no s1 entry is owned by it.
- busy = s1_valid | slot_a.valid | slot_b.valid.
- No width conversion or arithmetic: data passes bit-exact.

Test Plan:
- Reset then single request: A sends data=48'h0, tag=3; bank is the real S1..S8.
  - Required: req_ready_a=1 in the same cycle.
  - Required: two edges later rsp_valid_a=1, rsp_data_a=32'hEFA72C4D, rsp_tag_a=3.
  - Required: busy drops the cycle after rsp_ready_a.
- Contention: A and B both valid continuously, rsp_ready tied 1.
  - Required grant order A,B,A,B,…, one accept per cycle.
  - Required: each response appears 2 edges after its accept with the correct tag.
- Backpressure: A issues tag=1 with rsp_ready_a=0.
  - Required: rsp_valid_a holds, data/tag stable, req_ready_a=0 for A's next word.
  - Required: B issues every other cycle unaffected.
  - Release rsp_ready_a for one cycle → A's next word is accepted that same cycle.
- Single-requester throughput: only A valid for 10 cycles, rsp_ready_a=1.
  - Required: exactly 5 accepts, on alternating cycles.
- clear with s1 occupied and slot B full.
  - Required: next cycle rsp_valid_a=rsp_valid_b=0, busy=0, no late response.
  - Required: arbitration continues from the preserved last_grant.
- Async reset asserted mid-stream (between edges).
  - Required: all outputs go 0 immediately.
  - Required: after release, A wins the first tie.
